// File: rtl/ex_hazard_ctrl.sv
// Issue-side interlock for the EX1..EX4 + writeback pipeline: tracks in-flight
// destination registers and holds decode until every used source is written back.
module ex_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid_i,
    input  logic                  issue_we_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    input  logic [REG_ADDR_W-1:0] issue_ra_i,
    input  logic [REG_ADDR_W-1:0] issue_rb_i,
    input  logic [REG_ADDR_W-1:0] issue_rc_i,
    input  logic                  issue_ra_use_i,
    input  logic                  issue_rb_use_i,
    input  logic                  issue_rc_use_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  fire_o,
    output logic [2:0]            inflight_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    // Slot 0 is EX1, slot DEPTH-1 is the writeback cycle.
    logic [DEPTH-1:0]      slot_valid;
    logic [REG_ADDR_W-1:0] slot_rd [DEPTH];

    logic hazard;
    logic slot0_load;

    // Handshake: issue_valid_i is the offer from decode; fire_o accepts it this
    // cycle, stall_o asks decode to hold the same instruction stable until fire
    // or flush. Nothing is latched here, so the decision is recomputed each cycle.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_valid[k]) begin
                if (issue_ra_use_i && (slot_rd[k] == issue_ra_i)) hazard = 1'b1;
                if (issue_rb_use_i && (slot_rd[k] == issue_rb_i)) hazard = 1'b1;
                if (issue_rc_use_i && (slot_rd[k] == issue_rc_i)) hazard = 1'b1;
            end
        end
    end

    assign fire_o     = ~rst & issue_valid_i & ~hazard & ~flush_i;
    assign stall_o    = ~rst & issue_valid_i &  hazard & ~flush_i;
    assign slot0_load = fire_o & issue_we_i;

    // The execute pipe has no enable, so the scoreboard advances every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                slot_rd[k] <= '0;
            end
        end else begin
            slot_valid <= {slot_valid[DEPTH-2:0], slot0_load};
            slot_rd[0] <= slot0_load ? issue_rd_i : '0;
            for (int k = 1; k < DEPTH; k++) begin
                slot_rd[k] <= slot_rd[k-1];
            end
        end
    end

    always_comb begin
        inflight_o = 3'd0;
        for (int k = 0; k < DEPTH; k++) begin
            inflight_o = inflight_o + {2'b00, slot_valid[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: per-cycle {fire,stall,inflight}
// expectations are queued per scenario and popped as each cycle is observed.
module tb_ex_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       issue_valid;
    logic       issue_we;
    logic [4:0] issue_rd, issue_ra, issue_rb, issue_rc;
    logic       ra_use, rb_use, rc_use;
    logic       flush;

    logic        stall_o, fire_o;
    logic [2:0]  inflight_o;
    logic [15:0] stall_cnt_o;
    logic        stall_s, fire_s;
    logic [2:0]  inflight_s;
    logic [3:0]  stall_cnt_s;

    int total = 0;
    int bad   = 0;

    // {fire, stall, inflight}
    logic [4:0] exp_q[$];

    ex_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .issue_valid_i(issue_valid), .issue_we_i(issue_we),
        .issue_rd_i(issue_rd), .issue_ra_i(issue_ra),
        .issue_rb_i(issue_rb), .issue_rc_i(issue_rc),
        .issue_ra_use_i(ra_use), .issue_rb_use_i(rb_use), .issue_rc_use_i(rc_use),
        .flush_i(flush),
        .stall_o(stall_o), .fire_o(fire_o),
        .inflight_o(inflight_o), .stall_cnt_o(stall_cnt_o)
    );

    ex_hazard_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .issue_valid_i(issue_valid), .issue_we_i(issue_we),
        .issue_rd_i(issue_rd), .issue_ra_i(issue_ra),
        .issue_rb_i(issue_rb), .issue_rc_i(issue_rc),
        .issue_ra_use_i(ra_use), .issue_rb_use_i(rb_use), .issue_rc_use_i(rc_use),
        .flush_i(flush),
        .stall_o(stall_s), .fire_o(fire_s),
        .inflight_o(inflight_s), .stall_cnt_o(stall_cnt_s)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rc,
                         input logic ua, input logic ub, input logic uc);
        issue_valid = v;
        issue_we    = we;
        issue_rd    = rd;
        issue_ra    = ra;
        issue_rb    = rb;
        issue_rc    = rc;
        ra_use      = ua;
        rb_use      = ub;
        rc_use      = uc;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        idle_in();
        repeat (n) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        // rst still high: an offered instruction must be neither fired nor stalled
        drive(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1);
        #2;
        total++;
        if ({fire_o, stall_o} !== 2'b00) begin
            bad++;
            $display("FAIL reset_force fire/stall got=%b expected=00", {fire_o, stall_o});
        end
        total++;
        if (inflight_o !== 3'd0 || stall_cnt_o !== 16'd0 || stall_cnt_s !== 4'd0) begin
            bad++;
            $display("FAIL reset_state inflight=%0d cnt=%0d cnt_s=%0d expected 0/0/0",
                     inflight_o, stall_cnt_o, stall_cnt_s);
        end
        tick();
        rst = 1'b0;
        idle_in();
        #2;
        total++;
        if (inflight_o !== 3'd0) begin
            bad++;
            $display("FAIL reset_no_load inflight got=%0d expected=0", inflight_o);
        end
        tick();
    endtask

    task automatic test_independent();
        logic [4:0] e;
        do_reset();
        exp_q.push_back({2'b10, 3'd0});
        exp_q.push_back({2'b10, 3'd1});
        exp_q.push_back({2'b10, 3'd2});
        exp_q.push_back({2'b00, 3'd3});
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: drive(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0);
                1: drive(1'b1, 1'b1, 5'd4, 5'd5, 5'd6, 5'd0, 1'b1, 1'b1, 1'b0);
                2: drive(1'b1, 1'b1, 5'd7, 5'd8, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0);
                default: idle_in();
            endcase
            #2;
            e = exp_q.pop_front();
            total++;
            if ({fire_o, stall_o, inflight_o} !== e) begin
                bad++;
                $display("FAIL indep cyc=%0d fire,stall,inflight got=%b expected=%b",
                         c, {fire_o, stall_o, inflight_o}, e);
            end
            tick();
        end
        drain(6);
    endtask

    task automatic test_raw1();
        logic [4:0] e;
        do_reset();
        exp_q.push_back({2'b10, 3'd0});
        repeat (5) exp_q.push_back({2'b01, 3'd1});
        exp_q.push_back({2'b10, 3'd0});
        for (int c = 0; c < 7; c++) begin
            if (c == 0) drive(1'b1, 1'b1, 5'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            else        drive(1'b1, 1'b1, 5'd2, 5'd1, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0);
            #2;
            e = exp_q.pop_front();
            total++;
            if ({fire_o, stall_o, inflight_o} !== e) begin
                bad++;
                $display("FAIL raw1 cyc=%0d fire,stall,inflight got=%b expected=%b",
                         c, {fire_o, stall_o, inflight_o}, e);
            end
            tick();
        end
        idle_in();
        #2;
        total++;
        if (stall_cnt_o !== 16'd5) begin
            bad++;
            $display("FAIL raw1_cnt stall_cnt got=%0d expected=5", stall_cnt_o);
        end
        drain(6);
    endtask

    task automatic test_raw3();
        logic [4:0] e;
        do_reset();
        exp_q.push_back({2'b10, 3'd0});
        exp_q.push_back({2'b10, 3'd1});
        exp_q.push_back({2'b10, 3'd2});
        exp_q.push_back({2'b01, 3'd3});
        exp_q.push_back({2'b01, 3'd3});
        exp_q.push_back({2'b01, 3'd3});
        exp_q.push_back({2'b10, 3'd2});
        for (int c = 0; c < 7; c++) begin
            case (c)
                0: drive(1'b1, 1'b1, 5'd1,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
                1: drive(1'b1, 1'b1, 5'd10, 5'd4, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
                2: drive(1'b1, 1'b1, 5'd11, 5'd6, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0);
                default: drive(1'b1, 1'b1, 5'd12, 5'd8, 5'd9, 5'd1, 1'b1, 1'b1, 1'b1);
            endcase
            #2;
            e = exp_q.pop_front();
            total++;
            if ({fire_o, stall_o, inflight_o} !== e) begin
                bad++;
                $display("FAIL raw3 cyc=%0d fire,stall,inflight got=%b expected=%b",
                         c, {fire_o, stall_o, inflight_o}, e);
            end
            tick();
        end
        idle_in();
        #2;
        total++;
        if (stall_cnt_o !== 16'd3) begin
            bad++;
            $display("FAIL raw3_cnt stall_cnt got=%0d expected=3", stall_cnt_o);
        end
        drain(6);
    endtask

    task automatic test_unused_and_store();
        logic [4:0] e;
        do_reset();
        exp_q.push_back({2'b10, 3'd0});
        exp_q.push_back({2'b10, 3'd1});
        exp_q.push_back({2'b10, 3'd2});
        for (int c = 0; c < 3; c++) begin
            case (c)
                0: drive(1'b1, 1'b1, 5'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
                1: drive(1'b1, 1'b1, 5'd3, 5'd2, 5'd1, 5'd1, 1'b1, 1'b0, 1'b0);
                default: drive(1'b1, 1'b1, 5'd4, 5'd4, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
            endcase
            #2;
            e = exp_q.pop_front();
            total++;
            if ({fire_o, stall_o, inflight_o} !== e) begin
                bad++;
                $display("FAIL unused cyc=%0d fire,stall,inflight got=%b expected=%b",
                         c, {fire_o, stall_o, inflight_o}, e);
            end
            tick();
        end
        drain(6);
        exp_q.push_back({2'b10, 3'd0});
        exp_q.push_back({2'b10, 3'd0});
        exp_q.push_back({2'b00, 3'd1});
        for (int c = 0; c < 3; c++) begin
            case (c)
                0: drive(1'b1, 1'b0, 5'd1, 5'd6, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
                1: drive(1'b1, 1'b1, 5'd3, 5'd1, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0);
                default: idle_in();
            endcase
            #2;
            e = exp_q.pop_front();
            total++;
            if ({fire_o, stall_o, inflight_o} !== e) begin
                bad++;
                $display("FAIL store cyc=%0d fire,stall,inflight got=%b expected=%b",
                         c, {fire_o, stall_o, inflight_o}, e);
            end
            tick();
        end
        drain(6);
    endtask

    task automatic test_flush();
        logic [4:0] e;
        do_reset();
        exp_q.push_back({2'b10, 3'd0});
        exp_q.push_back({2'b01, 3'd1});
        exp_q.push_back({2'b00, 3'd1});
        exp_q.push_back({2'b00, 3'd1});
        exp_q.push_back({2'b00, 3'd1});
        exp_q.push_back({2'b00, 3'd1});
        exp_q.push_back({2'b00, 3'd0});
        exp_q.push_back({2'b00, 3'd0});
        exp_q.push_back({2'b00, 3'd0});
        for (int c = 0; c < 9; c++) begin
            flush = 1'b0;
            case (c)
                0: drive(1'b1, 1'b1, 5'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
                1: drive(1'b1, 1'b1, 5'd2, 5'd1, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0);
                2: begin
                    drive(1'b1, 1'b1, 5'd2, 5'd1, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0);
                    flush = 1'b1;
                end
                7: begin
                    drive(1'b1, 1'b1, 5'd9, 5'd4, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
                    flush = 1'b1;
                end
                default: idle_in();
            endcase
            #2;
            e = exp_q.pop_front();
            total++;
            if ({fire_o, stall_o, inflight_o} !== e) begin
                bad++;
                $display("FAIL flush cyc=%0d fire,stall,inflight got=%b expected=%b",
                         c, {fire_o, stall_o, inflight_o}, e);
            end
            tick();
        end
        idle_in();
        #2;
        total++;
        if (stall_cnt_o !== 16'd1) begin
            bad++;
            $display("FAIL flush_cnt stall_cnt got=%0d expected=1", stall_cnt_o);
        end
        drain(2);
    endtask

    task automatic test_reset_mid();
        logic [4:0] e;
        do_reset();
        exp_q.push_back({2'b10, 3'd0});
        exp_q.push_back({2'b10, 3'd1});
        exp_q.push_back({2'b10, 3'd2});
        exp_q.push_back({2'b01, 3'd3});
        exp_q.push_back({2'b00, 3'd3});
        exp_q.push_back({2'b10, 3'd0});
        for (int c = 0; c < 6; c++) begin
            rst = (c == 4);
            case (c)
                0: drive(1'b1, 1'b1, 5'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
                1: drive(1'b1, 1'b1, 5'd2, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
                2: drive(1'b1, 1'b1, 5'd3, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
                default: drive(1'b1, 1'b1, 5'd4, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0);
            endcase
            #2;
            e = exp_q.pop_front();
            total++;
            if ({fire_o, stall_o, inflight_o} !== e) begin
                bad++;
                $display("FAIL rst_mid cyc=%0d fire,stall,inflight got=%b expected=%b",
                         c, {fire_o, stall_o, inflight_o}, e);
            end
            if (c == 4) begin
                total++;
                if (stall_cnt_o !== 16'd1) begin
                    bad++;
                    $display("FAIL rst_mid_pre stall_cnt got=%0d expected=1", stall_cnt_o);
                end
            end
            if (c == 5) begin
                total++;
                if (stall_cnt_o !== 16'd0) begin
                    bad++;
                    $display("FAIL rst_mid_post stall_cnt got=%0d expected=0", stall_cnt_o);
                end
            end
            tick();
        end
        rst = 1'b0;
        drain(6);
    endtask

    task automatic test_saturation();
        logic [4:0] e;
        logic [4:0] rp, rc;
        do_reset();
        for (int it = 0; it < 4; it++) begin
            rp = 5'($urandom_range(1, 31));
            rc = 5'($urandom_range(1, 31));
            exp_q.push_back({2'b10, 3'd0});
            repeat (5) exp_q.push_back({2'b01, 3'd1});
            exp_q.push_back({2'b10, 3'd0});
            for (int c = 0; c < 7; c++) begin
                if (c == 0) drive(1'b1, 1'b1, rp, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
                else        drive(1'b1, 1'b1, rc, rp, rp, rp, 1'b1, 1'b0, 1'b0);
                #2;
                e = exp_q.pop_front();
                total++;
                if ({fire_o, stall_o, inflight_o} !== e) begin
                    bad++;
                    $display("FAIL sat it=%0d cyc=%0d fire,stall,inflight got=%b expected=%b",
                             it, c, {fire_o, stall_o, inflight_o}, e);
                end
                tick();
            end
            drain(6);
        end
        #2;
        total++;
        if (stall_cnt_o !== 16'd20) begin
            bad++;
            $display("FAIL sat_wide stall_cnt got=%0d expected=20", stall_cnt_o);
        end
        total++;
        if (stall_cnt_s !== 4'd15) begin
            bad++;
            $display("FAIL sat_narrow stall_cnt got=%0d expected=15", stall_cnt_s);
        end
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        idle_in();
        tick();
        test_reset();
        test_independent();
        test_raw1();
        test_raw3();
        test_unused_and_store();
        test_flush();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Issue-side interlock controller for the four-stage DSP48E1 execute pipeline (EX1–EX4 plus register-file writeback). It keeps a shift-register scoreboard of destination registers in flight and holds decode whenever an issuing instruction reads a register that has not yet been written back. When the hazard clears it releases the instruction, and a bubble enters EX1 on every stalled cycle. It sits between decode and the execute stage and replaces compiler-inserted NOP padding.

## Interface
- `REG_ADDR_W`, default 5: register address width; matches `reg_addr_width`.
- `DEPTH`, default 5: number of scoreboard slots, covering EX1, EX2, EX3, EX4 and writeback.
- `CNT_W`, default 16: width of the stall statistics counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `issue_valid_i`  in  1  decode presents an instruction this cycle.
- `issue_we_i`  in  1  the instruction writes the register file (word or upper half-word).
- `issue_rd_i`  in  REG_ADDR_W  destination register.
- `issue_ra_i`, `issue_rb_i`, `issue_rc_i`  in  REG_ADDR_W each  source registers.
- `issue_ra_use_i`, `issue_rb_use_i`, `issue_rc_use_i`  in  1 each  the corresponding source is actually read.
- `flush_i`  in  1  a taken branch kills the instruction at issue.
- `stall_o`  out  1  hold the fetch/decode registers this cycle.
- `fire_o`  out  1  the instruction enters EX1 this cycle.
- `inflight_o`  out  3  count of valid writing slots, 0..DEPTH.
- `stall_cnt_o`  out  CNT_W  saturating count of stalled cycles.

## Operation
- **Slot contents.** Each slot holds {valid, rd}. Slot 0 corresponds to EX1 and slot DEPTH-1 to the writeback cycle.
- **Hazard.** `hazard` is the OR over all sources s whose `use` bit is set, and all slots k, of (slot[k].valid && slot[k].rd == s).
  - All DEPTH slots are compared, because the register file is not write-through. A read in the writeback cycle would return stale data.
- **Issue decision (combinational):**
  - `fire_o = issue_valid_i & ~hazard & ~flush_i`
  - `stall_o = issue_valid_i & hazard & ~flush_i`
- **Shift on every cycle.** There is no execute-stage enable, so the scoreboard always advances:
  - slot[k] <= slot[k-1] for k = 1..DEPTH-1;
  - slot[DEPTH-1] is discarded.
- **Slot 0 load:**
  - slot[0] <= {fire_o & issue_we_i, issue_rd_i};
  - otherwise slot[0] <= {0, x}, i.e. a bubble;
  - rd is don't-care when valid = 0, but drive 0.
- **Flush** overrides a hazard:
  - the instruction at issue is dropped: no fire, no stall, no scoreboard entry;
  - slots already in flight are unaffected, since they are architecturally committed.
- **Self-dependency.** An instruction whose rd equals one of its own used sources follows the normal rules: the comparison is only against older slots.
- **`inflight_o`** is the population count of slot valid bits, taken from registers.
- **`stall_cnt_o`** increments by 1 on each cycle with `stall_o = 1` and saturates at 2^CNT_W−1.
- **Reset** (synchronous, `rst = 1` at an edge):
  - all slot valid bits = 0, all slot rd = 0, `stall_cnt_o` = 0;
  - while `rst` is asserted, `fire_o` and `stall_o` are forced to 0.
  - Reset mid-stall discards the pending hazard. The first post-reset issue fires immediately.

## Timing
- `stall_o` and `fire_o` are combinational from registered slots and same-cycle inputs. They must be valid before the decode/EX1 register edge.
- A producer fired at cycle T occupies slot k during cycles T+1+k, for k = 0..DEPTH-1.
- A dependent consumer presented from cycle T+1 stalls through T+DEPTH and fires at T+DEPTH+1.
  - With DEPTH = 5 this is 5 stall cycles.
- Back-to-back independent instructions fire on every cycle with zero bubbles.
- Once `stall_o` is asserted, decode holds its inputs stable. The controller re-evaluates every cycle and carries no internal stall state.
- Simultaneous events:
  - `flush_i` together with a hazard gives `stall_o = 0` and no fire.
  - A slot leaving writeback and a new issue at the same edge resolve correctly: the leaving slot is still compared in that cycle.

## Test plan
- **Independent stream.** Reset, then issue r1<=r2+r3, r4<=r5+r6, r7<=r8+r9 on consecutive cycles.
  - Required: `fire_o` = 1,1,1; `stall_o` never 1; `inflight_o` reaches 3.
- **RAW distance 1.** Issue r1<=..., then r2<=r1+r3 on the next cycle.
  - Required: `stall_o` high for exactly 5 cycles, `fire_o` on the 6th; `stall_cnt_o` = 5.
- **RAW distance 3.** Issue a producer of r1, two independent instructions, then a consumer of r1.
  - Required: the consumer stalls exactly 3 cycles.
- **Unused source and non-writer.**
  - A consumer has rb = r1 with `issue_rb_use_i = 0`: it fires with no stall.
  - A store (`issue_we_i = 0`) to rd = r1 followed by a read of r1: no stall.
- **Flush during stall.** A consumer is stalled on r1; assert `flush_i` on its 2nd stall cycle.
  - Required: `stall_o` = 0 and `fire_o` = 0 that cycle; no slot is added; `inflight_o` decrements normally.
- **Reset mid-operation and saturation.**
  - Assert `rst` with 3 valid slots and a pending stall: the next cycle shows `inflight_o` = 0, `stall_cnt_o` = 0, and the held consumer fires.
  - With CNT_W = 4, force 20 stall cycles: `stall_cnt_o` holds at 15.
